pingpong_ram: RTL and testbench

Double-buffered (ping-pong) storage between a producer on port A and a consumer on port B, both in the `clk` domain. Two equal RAM banks alternate ownership: port A fills one bank while port B drains the other. Ownership swaps via `finisha`/`finishb` completion strobes. The block sits between a frame/packet source (e.g. a SPI receiver) and a downstream reader, decoupling their timing by one whole buffer.

---
 rtl/pingpong_ram_pkg.sv | 14 +
 rtl/pingpong_ram_if.sv | 29 ++
 rtl/pingpong_ram_bank.sv | 32 +++
 rtl/pingpong_ram.sv | 92 +++++++++
 tb/tb_pingpong_ram.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pingpong_ram_pkg.sv
// rtl/pingpong_ram_pkg.sv - shared types and default sizes for the ping-pong buffer
package pingpong_ram_pkg;

    localparam int PP_ADDR_W = 7;
    localparam int PP_DATA_W = 8;

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

    typedef logic bank_idx_t;

endpackage

// File: rtl/pingpong_ram_if.sv
// rtl/pingpong_ram_if.sv - producer/consumer port bundle of the ping-pong buffer
interface pingpong_ram_if
    import pingpong_ram_pkg::*;
#(
    parameter int ADDR_W = PP_ADDR_W,
    parameter int DATA_W = PP_DATA_W
);

    logic [ADDR_W-1:0] addra;
    logic              wea;
    logic [DATA_W-1:0] dina;
    logic              finisha;
    logic              readya;
    logic [ADDR_W-1:0] addrb;
    logic              finishb;
    logic [DATA_W-1:0] doutb;
    logic              readyb;

    modport master (
        output addra, wea, dina, finisha, addrb, finishb,
        input  readya, doutb, readyb
    );

    modport slave (
        input  addra, wea, dina, finisha, addrb, finishb,
        output readya, doutb, readyb
    );

endinterface

// File: rtl/pingpong_ram_bank.sv
// rtl/pingpong_ram_bank.sv - one simple dual-port bank, synchronous write and read
module pingpong_ram_bank #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pingpong_ram.sv
// rtl/pingpong_ram.sv - two-bank ping-pong buffer; PINGPONG_RAM_DOUT_REG_EN adds a doutb output stage
module pingpong_ram
    import pingpong_ram_pkg::*;
#(
    parameter int ADDR_W = PP_ADDR_W,
    parameter int DATA_W = PP_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    pingpong_ram_if.slave  bus
);

    bank_state_t       state [2];
    bank_idx_t         wsel;
    bank_idx_t         rsel;
    bank_idx_t         rsel_q;
    logic              readya;
    logic              readyb;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] rdata [2];
    logic [DATA_W-1:0] rd_mux;

    assign readya = (state[wsel] == BANK_FREE);
    assign readyb = (state[rsel] == BANK_FULL);
    assign bus.readya = readya;
    assign bus.readyb = readyb;

    assign we0 = bus.wea && readya && (wsel == 1'b0);
    assign we1 = bus.wea && readya && (wsel == 1'b1);

    pingpong_ram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .we    (we0),
        .waddr (bus.addra),
        .wdata (bus.dina),
        .raddr (bus.addrb),
        .rdata (rdata[0])
    );

    pingpong_ram_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .we    (we1),
        .waddr (bus.addra),
        .wdata (bus.dina),
        .raddr (bus.addrb),
        .rdata (rdata[1])
    );

    // When both strobes are accepted they necessarily target different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state[0] <= BANK_FREE;
            state[1] <= BANK_FREE;
            wsel     <= 1'b0;
            rsel     <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            if (bus.finisha && readya) begin
                state[wsel] <= BANK_FULL;
                wsel        <= ~wsel;
            end
            if (bus.finishb && readyb) begin
                state[rsel] <= BANK_FREE;
                rsel        <= ~rsel;
            end
            rsel_q <= rsel;
        end
    end

    // rsel_q remembers which bank was read at the last edge, before any handover.
    assign rd_mux = rdata[rsel_q];

`ifdef PINGPONG_RAM_DOUT_REG_EN
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= rd_mux;
        end
    end

    assign bus.doutb = dout_q;
`else
    assign bus.doutb = rd_mux;
`endif

endmodule

// File: tb/tb_pingpong_ram.sv
// tb/tb_pingpong_ram.sv - scoreboard bench for pingpong_ram against a bank-ownership model
module tb_pingpong_ram;

`ifdef PINGPONG_RAM_DOUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    pingpong_ram_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    pingpong_ram #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; bit ra; bit rb; } st_e_t;
    typedef struct { int due; logic [7:0] d; } d_e_t;
    st_e_t sq[$];
    d_e_t  dq[$];

    // Reference model: bank contents, which words were ever written, ownership.
    logic [7:0] mm [2][128];
    bit         wr [2][128];
    bit         st [2];
    bit         ws;
    bit         rs;

    st_e_t se;
    d_e_t  de;

    always @(negedge clk) begin
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            se = sq.pop_front();
            tests++;
            if (se.due < cyc) begin
                fails++;
                $display("FAIL status_missed cyc=%0d due=%0d", cyc, se.due);
            end else if (bus.readya !== se.ra || bus.readyb !== se.rb) begin
                fails++;
                $display("FAIL ready cyc=%0d got readya=%b readyb=%b exp readya=%b readyb=%b",
                         cyc, bus.readya, bus.readyb, se.ra, se.rb);
            end
        end
        while (dq.size() > 0 && dq[0].due <= cyc) begin
            de = dq.pop_front();
            tests++;
            if (de.due < cyc) begin
                fails++;
                $display("FAIL doutb_missed cyc=%0d due=%0d", cyc, de.due);
            end else if (bus.doutb !== de.d) begin
                fails++;
                $display("FAIL doutb cyc=%0d got %h exp %h", cyc, bus.doutb, de.d);
            end
        end
    end

    task automatic step(input bit r, input bit we, input int aa, input int d,
                        input bit fa, input int ab, input bit fb, input bit chk);
        int         k = cyc;
        bit         rap;
        bit         rbp;
        bit         rdv;
        logic [7:0] rd;
        logic [7:0] dv;
        rst         = r;
        bus.wea     = we;
        bus.addra   = aa[6:0];
        bus.dina    = d[7:0];
        bus.finisha = fa;
        bus.addrb   = ab[6:0];
        bus.finishb = fb;
        dv  = d[7:0];
        rap = !st[ws];
        rbp = st[rs];
        rd  = mm[rs][ab[6:0]];
        rdv = rbp && wr[rs][ab[6:0]];
        if (r) begin
            st[0] = 1'b0;
            st[1] = 1'b0;
            ws    = 1'b0;
            rs    = 1'b0;
        end else begin
            if (we && rap) begin
                mm[ws][aa[6:0]] = dv;
                wr[ws][aa[6:0]] = 1'b1;
            end
            if (fa && rap) begin
                st[ws] = 1'b1;
                ws     = !ws;
            end
            if (fb && rbp) begin
                st[rs] = 1'b0;
                rs     = !rs;
            end
        end
        if (chk) begin
            sq.push_back('{k + 1, !st[ws], st[rs]});
            if (r)        dq.push_back('{k + 1, 8'h00});
            else if (rdv) dq.push_back('{k + LAT, rd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit chk);
        step(0, 0, 0, 0, 0, 0, 0, chk);
    endtask

    task automatic do_reset();
        idle(0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic wr_word(input int a, input int d);
        step(0, 1, a, d, 0, 0, 0, 1);
    endtask

    task automatic rd_word(input int a);
        step(0, 0, 0, 0, 0, a, 0, 1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 64; i++) wr_word(i, i);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 64; i++) rd_word(i);

        for (int i = 0; i < 64; i++) wr_word(i, 100 + i);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 8; i++) wr_word(i, 8'hEE);
        for (int i = 0; i < 64; i++) rd_word(i);

        step(0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 64; i++) rd_word(i);

        step(0, 0, 0, 0, 1, 5, 1, 1);
        for (int i = 0; i < 8; i++) rd_word(i);

        for (int i = 0; i < 30; i++) wr_word(i, 8'h55 ^ i);
        do_reset();
        for (int i = 0; i < 64; i++) wr_word(i, 200 - i);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 64; i++) rd_word(i);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 255)), $urandom_range(0, 15) == 0,
                     int'($urandom_range(0, 15)), $urandom_range(0, 15) == 0, 1);
            end
        end

        repeat (LAT + 2) idle(1);
        repeat (LAT + 2) @(negedge clk);
        tests++;
        if (sq.size() != 0 || dq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d/%0d pending exp 0/0", sq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
